network_conv_acc: RTL
=====================

# network_conv_acc

Streaming accumulator stage directly downstream of the 16-bit signed product multiplier in the convolution datapath. Consumes one truncated 16-bit product per handshake and sums TAPS products per output pixel. Adds a per-run bias, rescales, saturates to 16 bits and presents one result per pixel on a valid/ready output register. Block-level start/done control lets the layer controller run it for a programmed number of pixels.

## Interface
- TAPS, 9, products summed per output pixel (3x3 kernel); legal range 1..256
- ACC_WIDTH, 32, accumulator width; must be ≥ 17 + clog2(TAPS)
- SHIFT, 0, arithmetic right shift applied to (sum + bias) before saturation; legal range 0..15

- ap_clk  in  1  clock; all state changes on its rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  start request; sampled only in IDLE
- ap_done  out  1  one-cycle pulse when the run completes
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  equal to ap_done
- npix  in  16  unsigned pixel count; captured when start is accepted
- bias  in  16  signed bias; captured when start is accepted
- prod_din  in  16  signed product from the multiplier
- prod_vld  in  1  product valid
- prod_rdy  out  1  product accepted when prod_vld && prod_rdy
- out_data  out  16  signed result
- out_vld  out  1  result valid; held until consumed
- out_rdy  in  1  consumer ready

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: prod_rdy=0. On ap_start, capture npix into pix_left and bias into bias_r.
  - If npix=0, pulse ap_done next cycle and stay in IDLE.
  - Otherwise go to RUN with tap_cnt=0 and acc=0.
- RUN: prod_rdy=1, except at tap_cnt=TAPS-1 while out_vld && !out_rdy; a full output register stalls only the last tap.
  - Each accepted product: acc += sign-extended prod_din; tap_cnt++.
  - On the last tap:
    - s = acc + prod_din + bias, all sign-extended to ACC_WIDTH.
    - r = s >>> SHIFT.
    - out_data = r saturated to [-32768, 32767].
    - out_vld is set; acc and tap_cnt clear; pix_left decrements.
  - If pix_left reaches 0, go to DRAIN.
- DRAIN: prod_rdy=0. When out_vld && out_rdy, go to IDLE and pulse ap_done/ap_ready.
- Output register: out_vld clears on out_vld && out_rdy unless a new result loads in the same cycle. A simultaneous consume and load keeps out_vld=1 with the new data.
- ap_start outside IDLE is ignored. Inputs npix and bias are don't-care outside the start cycle.
- Products arriving while prod_rdy=0 are neither consumed nor lost; the upstream producer holds them.

## Timing
- Reset values:
  - state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, prod_rdy=0
  - out_vld=0, out_data=0
  - acc=0, tap_cnt=0, pix_left=0, bias_r=0
- Reset mid-run discards the partial sum and any pending output without raising ap_done.
- Latency: out_vld rises on the clock edge after the last-tap handshake, so the result is visible 1 cycle later.
- Throughput: 1 product per cycle while out_rdy=1; one pixel every TAPS cycles.
- ap_done: a single-cycle pulse in the cycle after the final output handshake. ap_idle rises in that same cycle.
- Start: the first product can be accepted in the cycle after ap_start is sampled.

## Configuration
- NETWORK_CONV_ACC_RELU_EN defined: after saturation, negative results are forced to 0, so out_data ranges over 0..32767.
- Not defined: the saturated signed result passes through unchanged.
- Nothing else depends on the macro.

## Test plan
- Basic pixel: TAPS=9, SHIFT=0, npix=1, bias=5, products 1..9 with out_rdy=1.
  - out_data=50 one cycle after the 9th product.
  - ap_done pulses the cycle after the output handshake.
- Saturation: 9 products of 32767 with bias=0.
  - out_data=32767.
  - 9 products of -32768 give out_data=-32768, or 0 with NETWORK_CONV_ACC_RELU_EN.
- Shift/sign: SHIFT=2, bias=-3, products all 0 except one of -8.
  - s=-11, so out_data=-3 (arithmetic shift rounds toward negative infinity).
- Backpressure: npix=3, products streamed continuously with out_rdy held 0.
  - The 2nd pixel's last tap stalls with prod_rdy=0 until out_rdy=1.
  - No products are lost; results appear in order.
  - ap_done fires only after the 3rd result is consumed.
- Edge cases: ap_start with npix=0 gives an ap_done pulse next cycle and no out_vld. A second ap_start during RUN is ignored.
- Mid-run reset: assert ap_rst after 4 taps.
  - All outputs return to reset values.
  - A new run with npix=1 and products 1..9, bias=0 yields out_data=45.

Source files
------------

// File: rtl/network_conv_acc.sv
// network_conv_acc: streaming multiply-accumulate tail for the convolution
// datapath. Sums TAPS signed 16-bit products per output pixel, adds a per-run
// bias, arithmetic-shifts by SHIFT, saturates to 16 bits and presents one
// result per pixel on a valid/ready output register. A start/done handshake
// runs the block for npix pixels.
//
// Optional feature macro: NETWORK_CONV_ACC_RELU_EN (negative results -> 0).
//
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   ap_start            start request, sampled only while idle
//   ap_done, ap_ready   one-cycle pulse when a run completes (identical)
//   ap_idle             high while idle
//   npix, bias          pixel count / signed bias, captured on accepted start
//   prod_din/vld/rdy    product input stream
//   out_data/vld/rdy    result output stream
module network_conv_acc #(
    parameter int unsigned TAPS      = 9,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SHIFT     = 0
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [15:0] npix,
    input  logic [15:0] bias,
    input  logic [15:0] prod_din,
    input  logic        prod_vld,
    output logic        prod_rdy,
    output logic [15:0] out_data,
    output logic        out_vld,
    input  logic        out_rdy
);

    localparam int unsigned CNT_W = $clog2(TAPS + 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sd32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32'sd32768);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic                          done_r;
    logic                          done_nxt;
    logic                          start_acc;

    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [CNT_W-1:0]       tap_cnt;
    logic        [15:0]            pix_left;
    logic        [15:0]            bias_r;

    logic                          last_tap;
    logic                          prod_hs;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   sum_s;
    logic signed [ACC_WIDTH-1:0]   shr_s;
    logic        [15:0]            sat_c;
    logic        [15:0]            res_c;

    assign ap_done  = done_r;
    assign ap_ready = done_r;
    assign ap_idle  = (state == IDLE);

    assign last_tap = (tap_cnt == CNT_W'(TAPS - 1));
    assign prod_hs  = prod_vld && prod_rdy;

    // State and done-pulse registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= done_nxt;
        end
    end

    // Next-state, start capture and product-ready decode
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        start_acc = 1'b0;
        prod_rdy  = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    start_acc = 1'b1;
                    if (npix == 16'd0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // Only the last tap needs a free output slot
                prod_rdy = !(last_tap && out_vld && !out_rdy);
                if (prod_vld && prod_rdy && last_tap && (pix_left == 16'd1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_vld && out_rdy) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final sum, rescale and saturation for the last tap
    always_comb begin
        prod_ext = {{(ACC_WIDTH - 16){prod_din[15]}}, prod_din};
        bias_ext = {{(ACC_WIDTH - 16){bias_r[15]}}, bias_r};
        sum_s    = acc + prod_ext + bias_ext;
        shr_s    = sum_s >>> SHIFT;
        sat_c    = shr_s[15:0];
        if (shr_s > SAT_MAX) begin
            sat_c = 16'h7fff;
        end else if (shr_s < SAT_MIN) begin
            sat_c = 16'h8000;
        end
`ifdef NETWORK_CONV_ACC_RELU_EN
        res_c = sat_c[15] ? 16'd0 : sat_c;
`else
        res_c = sat_c;
`endif
    end

    // Accumulator, counters and output register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc      <= '0;
            tap_cnt  <= '0;
            pix_left <= 16'd0;
            bias_r   <= 16'd0;
            out_vld  <= 1'b0;
            out_data <= 16'd0;
        end else begin
            if (start_acc) begin
                pix_left <= npix;
                bias_r   <= bias;
                acc      <= '0;
                tap_cnt  <= '0;
            end
            if (prod_hs) begin
                if (last_tap) begin
                    acc      <= '0;
                    tap_cnt  <= '0;
                    pix_left <= pix_left - 16'd1;
                end else begin
                    acc     <= acc + prod_ext;
                    tap_cnt <= tap_cnt + CNT_W'(1);
                end
            end
            // A load in the same cycle as a consume keeps out_vld high
            if (prod_hs && last_tap) begin
                out_vld  <= 1'b1;
                out_data <= res_c;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule
